// File: rtl/alpaca_sdf_feeder.sv
// Radix-2 SDF delay-commutator: buffers the first FFT_LEN/2 samples of a frame and emits (s[n], s[n+FFT_LEN/2]) pairs.
// Optional statistics counters (frames, tlast_errs) are built only when ALPACA_FEEDER_STATS_EN is defined.
module alpaca_sdf_feeder #(
  parameter int unsigned FFT_LEN = 16,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TUSER_W = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2*WIDTH-1:0]   i_s_axis_tdata,
  input  logic                 i_s_axis_tvalid,
  output logic                 o_s_axis_tready,
  input  logic                 i_s_axis_tlast,
  input  logic [TUSER_W-1:0]   i_s_axis_tuser,
  output logic [2*WIDTH-1:0]   o_x1_tdata,
  output logic [TUSER_W-1:0]   o_x1_tuser,
  output logic                 o_x1_tvalid,
  output logic                 o_x1_tlast,
  input  logic                 i_x1_tready,
  output logic [2*WIDTH-1:0]   o_x2_tdata,
  output logic [TUSER_W-1:0]   o_x2_tuser,
  output logic                 o_x2_tvalid,
  output logic                 o_x2_tlast,
  input  logic                 i_x2_tready,
  output logic                 o_frame_err,
  output logic [31:0]          o_frames,
  output logic [15:0]          o_tlast_errs
);

  localparam int unsigned DELAY   = FFT_LEN / 2;
  localparam int unsigned CNT_W   = $clog2(FFT_LEN);
  localparam int unsigned ADDR_W  = CNT_W - 1;
  localparam int unsigned DATA_W  = 2 * WIDTH;
  localparam int unsigned ENTRY_W = DATA_W + TUSER_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FFT_LEN - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [ENTRY_W-1:0] r_buf [DELAY];
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_x1_data;
  logic [TUSER_W-1:0] r_x1_user;
  logic [DATA_W-1:0]  r_x2_data;
  logic [TUSER_W-1:0] r_x2_user;
  logic               r_x2_last;
  logic               r_frame_err;

  logic               w_pair;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_at_last;
  logic               w_out_fire;
  logic               w_accept;
  logic               w_early;
  logic               w_missing;
  logic               w_err_evt;
  logic               w_load;
  logic               w_wr;
  logic [ENTRY_W-1:0] w_buf_rd;

  // Upper half of the count is the PAIR phase; the low bits address the delay buffer in both phases.
  assign w_pair     = r_cnt[CNT_W-1];
  assign w_addr     = r_cnt[ADDR_W-1:0];
  assign w_at_last  = (r_cnt == LAST_CNT);
  assign w_out_fire = r_out_valid & i_x1_tready & i_x2_tready;

  // Ready is a pass-through of downstream ready so a consumed pair can be replaced in the same cycle.
  assign o_s_axis_tready = ~i_rst & (~w_pair | ~r_out_valid | (i_x1_tready & i_x2_tready));

  assign w_accept  = i_s_axis_tvalid & o_s_axis_tready;
  assign w_early   = w_accept & i_s_axis_tlast & ~w_at_last;
  assign w_missing = w_accept & ~i_s_axis_tlast & w_at_last;
  assign w_err_evt = w_early | w_missing;
  assign w_load    = w_accept & w_pair & ~w_early;
  assign w_wr      = w_accept & ~w_pair & ~w_early;
  assign w_buf_rd  = r_buf[w_addr];

  // Delay buffer: written only in FILL, read only in PAIR, so no read/write collision.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_buf[w_addr] <= {i_s_axis_tdata, i_s_axis_tuser};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_x1_data   <= '0;
      r_x1_user   <= '0;
      r_x2_data   <= '0;
      r_x2_user   <= '0;
      r_x2_last   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_early ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_x1_data   <= w_buf_rd[ENTRY_W-1:TUSER_W];
        r_x1_user   <= w_buf_rd[TUSER_W-1:0];
        r_x2_data   <= i_s_axis_tdata;
        r_x2_user   <= i_s_axis_tuser;
        r_x2_last   <= w_at_last;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_err_evt) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign o_x1_tdata  = r_x1_data;
  assign o_x1_tuser  = r_x1_user;
  assign o_x1_tvalid = r_out_valid;
  assign o_x1_tlast  = 1'b0;
  assign o_x2_tdata  = r_x2_data;
  assign o_x2_tuser  = r_x2_user;
  assign o_x2_tvalid = r_out_valid;
  assign o_x2_tlast  = r_x2_last;
  assign o_frame_err = r_frame_err;

`ifdef ALPACA_FEEDER_STATS_EN
  logic [31:0] r_frames;
  logic [15:0] r_tlast_errs;

  // Frames count consumed end-of-frame pairs; error count saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frames     <= '0;
      r_tlast_errs <= '0;
    end else begin
      if (w_out_fire & r_x2_last) begin
        r_frames <= r_frames + 32'd1;
      end
      if (w_err_evt && (r_tlast_errs != 16'hFFFF)) begin
        r_tlast_errs <= r_tlast_errs + 16'd1;
      end
    end
  end

  assign o_frames     = r_frames;
  assign o_tlast_errs = r_tlast_errs;
`else
  assign o_frames     = '0;
  assign o_tlast_errs = '0;
`endif

endmodule

// File: tb/tb_alpaca_sdf_feeder.sv
// Directed self-checking bench for alpaca_sdf_feeder (FFT_LEN=16, WIDTH=16, 4-bit tuser).
// Honours ALPACA_FEEDER_STATS_EN for the statistics expectations.
module tb_alpaca_sdf_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [3:0]  s_tuser;
  logic [31:0] x1_tdata;
  logic [3:0]  x1_tuser;
  logic        x1_tvalid;
  logic        x1_tlast;
  logic        x1_tready;
  logic [31:0] x2_tdata;
  logic [3:0]  x2_tuser;
  logic        x2_tvalid;
  logic        x2_tlast;
  logic        x2_tready;
  logic        frame_err;
  logic [31:0] frames;
  logic [15:0] tlast_errs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alpaca_sdf_feeder #(.FFT_LEN(16), .WIDTH(16), .TUSER_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tdata(s_tdata), .i_s_axis_tvalid(s_tvalid), .o_s_axis_tready(s_tready),
    .i_s_axis_tlast(s_tlast), .i_s_axis_tuser(s_tuser),
    .o_x1_tdata(x1_tdata), .o_x1_tuser(x1_tuser), .o_x1_tvalid(x1_tvalid),
    .o_x1_tlast(x1_tlast), .i_x1_tready(x1_tready),
    .o_x2_tdata(x2_tdata), .o_x2_tuser(x2_tuser), .o_x2_tvalid(x2_tvalid),
    .o_x2_tlast(x2_tlast), .i_x2_tready(x2_tready),
    .o_frame_err(frame_err), .o_frames(frames), .o_tlast_errs(tlast_errs)
  );

  // Sample n of frame f: re = f*32+n, im = -(f*32+n).
  function automatic logic [31:0] sd(input int f, input int n);
    int v;
    v = f * 32 + n;
    return {16'(v), 16'(-v)};
  endfunction

  function automatic logic [3:0] su(input int f, input int n);
    return 4'(n + 3 * f);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and wait (bounded) until it is accepted; returns #1 after the accepting edge.
  task automatic push(input int f, input int n, input logic last, output logic rdy_first);
    logic done;
    int   i;
    s_tvalid = 1'b1;
    s_tdata  = sd(f, n);
    s_tuser  = su(f, n);
    s_tlast  = last;
    #1;
    rdy_first = s_tready;
    done = 1'b0;
    i = 0;
    while (!done && i < 32) begin
      if (s_tready) done = 1'b1;
      @(posedge clk);
      #1;
      i++;
    end
    chk($sformatf("accept f%0d n%0d", f, n), 64'(done), 64'(1));
  endtask

  task automatic check_pair(input int f, input int k);
    chk($sformatf("x1_valid f%0d k%0d", f, k), 64'(x1_tvalid), 64'(1));
    chk($sformatf("x2_valid f%0d k%0d", f, k), 64'(x2_tvalid), 64'(1));
    chk($sformatf("x1_data f%0d k%0d", f, k), 64'(x1_tdata), 64'(sd(f, k)));
    chk($sformatf("x1_user f%0d k%0d", f, k), 64'(x1_tuser), 64'(su(f, k)));
    chk($sformatf("x2_data f%0d k%0d", f, k), 64'(x2_tdata), 64'(sd(f, k + 8)));
    chk($sformatf("x2_user f%0d k%0d", f, k), 64'(x2_tuser), 64'(su(f, k + 8)));
    chk($sformatf("x2_last f%0d k%0d", f, k), 64'(x2_tlast), 64'(k == 7));
    chk($sformatf("x1_last f%0d k%0d", f, k), 64'(x1_tlast), 64'(0));
  endtask

  // Full frame with downstream always ready: no output during FILL, pair k right after s[k+8].
  task automatic run_frame(input int f, input logic with_tlast);
    logic r;
    for (int n = 0; n < 16; n++) begin
      push(f, n, with_tlast && (n == 15), r);
      chk($sformatf("tready f%0d n%0d", f, n), 64'(r), 64'(1));
      if (n < 8) chk($sformatf("fill_valid f%0d n%0d", f, n), 64'(x1_tvalid), 64'(0));
      else       check_pair(f, n - 8);
    end
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    rst       = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tlast   = 1'b0;
    s_tuser   = '0;
    x1_tready = 1'b1;
    x2_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_x1_valid", 64'(x1_tvalid), 64'(0));
    chk("rst_x2_valid", 64'(x2_tvalid), 64'(0));
    chk("rst_x2_last", 64'(x2_tlast), 64'(0));
    chk("rst_x1_data", 64'(x1_tdata), 64'(0));
    chk("rst_x2_data", 64'(x2_tdata), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    chk("rst_frames", 64'(frames), 64'(0));
    chk("rst_tlast_errs", 64'(tlast_errs), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_tready", 64'(s_tready), 64'(1));

    // T1: single frame
    run_frame(0, 1'b1);
    // T2: three back-to-back frames, tvalid never dropped
    run_frame(1, 1'b1);
    run_frame(2, 1'b1);
    run_frame(3, 1'b1);
    chk("t2_frame_err", 64'(frame_err), 64'(0));

    // T3: x2 backpressure for 4 cycles while pair 3 is held
    for (int n = 0; n < 8; n++) begin
      push(4, n, 1'b0, r);
      chk($sformatf("t3_fill_valid n%0d", n), 64'(x1_tvalid), 64'(0));
    end
    for (int k = 0; k < 4; k++) begin
      push(4, k + 8, 1'b0, r);
      check_pair(4, k);
    end
    x2_tready = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = sd(4, 12);
    s_tuser   = su(4, 12);
    s_tlast   = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t3_hold_tready c%0d", c), 64'(s_tready), 64'(0));
      @(posedge clk); #1;
      chk($sformatf("t3_hold_valid c%0d", c), 64'(x1_tvalid & x2_tvalid), 64'(1));
      chk($sformatf("t3_hold_x1 c%0d", c), 64'(x1_tdata), 64'(sd(4, 3)));
      chk($sformatf("t3_hold_x2 c%0d", c), 64'(x2_tdata), 64'(sd(4, 11)));
    end
    x2_tready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      push(4, k + 8, k == 7, r);
      check_pair(4, k);
    end

    // T4: early tlast on sample 5, then a clean frame
    for (int n = 0; n < 6; n++) begin
      push(5, n, n == 5, r);
      chk($sformatf("t4_no_out n%0d", n), 64'(x1_tvalid), 64'(0));
    end
    chk("t4_frame_err_set", 64'(frame_err), 64'(1));
    run_frame(6, 1'b1);
    chk("t4_frame_err_sticky", 64'(frame_err), 64'(1));
`ifdef ALPACA_FEEDER_STATS_EN
    chk("t4_tlast_errs", 64'(tlast_errs), 64'(1));
`else
    chk("t4_tlast_errs", 64'(tlast_errs), 64'(0));
`endif

    // T5: reset after sample 10 of a frame
    for (int n = 0; n < 11; n++) begin
      push(7, n, 1'b0, r);
      if (n >= 8) check_pair(7, n - 8);
    end
    rst      = 1'b1;
    s_tvalid = 1'b0;
    #1;
    chk("t5_rst_tready", 64'(s_tready), 64'(0));
    @(posedge clk); #1;
    chk("t5_valid_low", 64'(x1_tvalid | x2_tvalid), 64'(0));
    chk("t5_frame_err_clr", 64'(frame_err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_no_stale", 64'(x1_tvalid | x2_tvalid), 64'(0));
    run_frame(8, 1'b1);

    // T6: five clean frames from reset
    do_reset();
    for (int f = 10; f < 15; f++) run_frame(f, 1'b1);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("t6_drained", 64'(x1_tvalid), 64'(0));
    chk("t6_frame_err", 64'(frame_err), 64'(0));
`ifdef ALPACA_FEEDER_STATS_EN
    chk("t6_frames", 64'(frames), 64'(5));
`else
    chk("t6_frames", 64'(frames), 64'(0));
`endif
    chk("t6_tlast_errs", 64'(tlast_errs), 64'(0));

    // Missing tlast on the final sample: pairs still produced, error flagged
    run_frame(15, 1'b0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("miss_frame_err", 64'(frame_err), 64'(1));
`ifdef ALPACA_FEEDER_STATS_EN
    chk("miss_frames", 64'(frames), 64'(6));
    chk("miss_tlast_errs", 64'(tlast_errs), 64'(1));
`else
    chk("miss_frames", 64'(frames), 64'(0));
    chk("miss_tlast_errs", 64'(tlast_errs), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
